// File: rtl/wb_stage_if.sv
// Writeback stage bus bundle: memory-stage handoff, data-memory load
// response, pipeline flush and the register-file write port.
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_alu_result;
  logic        mem_is_load;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_retire;

  // Upstream side: memory stage, data memory and pipeline control.
  modport master (
    output mem_valid, mem_wen, mem_waddr, mem_alu_result, mem_is_load,
           mem_load_type, mem_addr_lo, dmem_rvalid, dmem_rdata, flush,
    input  mem_ready, rf_we, rf_waddr, rf_wdata, wb_retire
  );

  // The writeback stage itself.
  modport slave (
    input  mem_valid, mem_wen, mem_waddr, mem_alu_result, mem_is_load,
           mem_load_type, mem_addr_lo, dmem_rvalid, dmem_rdata, flush,
    output mem_ready, rf_we, rf_waddr, rf_wdata, wb_retire
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for load data,
// aligns/extends it and drives the register file write port. Flushed loads
// whose response is still in flight are drained so the response is dropped.
module wb_stage (
  input logic       clk,
  input logic       reset,
  wb_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    WAIT_LOAD = 2'd2,
    DRAIN     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        heldWen_q, heldWen_d;
  logic [4:0]  heldAddr_q, heldAddr_d;
  logic [31:0] heldAlu_q, heldAlu_d;
  logic [2:0]  heldType_q, heldType_d;
  logic [1:0]  heldLo_q, heldLo_d;

  logic        commit;
  logic        ready;
  logic        accept;
  logic        writeEn;
  logic [31:0] shifted;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;

  // Pick the addressed byte/half out of the little-endian response word and
  // extend it according to the held load type; unknown codes act as LW.
  always_comb begin
    shifted  = bus.dmem_rdata >> {heldLo_q, 3'b000};
    loadByte = shifted[7:0];
    loadHalf = heldLo_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (heldType_q)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadData = {24'd0, loadByte};
      3'b101:  loadData = {16'd0, loadHalf};
      default: loadData = bus.dmem_rdata;
    endcase
  end

  // Commit/accept decisions; only state, rvalid and flush feed the outputs,
  // mem_valid reaches nothing but the next-state logic.
  always_comb begin
    commit  = reset & ~bus.flush &
              ((state_q == FULL) | ((state_q == WAIT_LOAD) & bus.dmem_rvalid));
    ready   = reset & ((state_q == EMPTY) | commit);
    accept  = bus.mem_valid & ready & ~bus.flush;
    writeEn = commit & heldWen_q & (heldAddr_q != 5'd0);
  end

  // Drive the register-file port; address and data are forced to zero
  // whenever no write happens so the port is quiet between writes.
  always_comb begin
    bus.mem_ready = ready;
    bus.wb_retire = commit;
    bus.rf_we     = writeEn;
    bus.rf_waddr  = writeEn ? heldAddr_q : 5'd0;
    bus.rf_wdata  = 32'd0;
    if (writeEn) begin
      bus.rf_wdata = (state_q == WAIT_LOAD) ? loadData : heldAlu_q;
    end
  end

  // Next-state: flush wins over commit and accept. A drain always ends on
  // the response, even if a flush arrives with it, so it can never hang.
  always_comb begin
    state_d    = state_q;
    heldWen_d  = heldWen_q;
    heldAddr_d = heldAddr_q;
    heldAlu_d  = heldAlu_q;
    heldType_d = heldType_q;
    heldLo_d   = heldLo_q;
    if (bus.flush) begin
      case (state_q)
        FULL:      state_d = EMPTY;
        WAIT_LOAD: state_d = bus.dmem_rvalid ? EMPTY : DRAIN;
        DRAIN:     state_d = bus.dmem_rvalid ? EMPTY : DRAIN;
        default:   state_d = state_q;
      endcase
    end else begin
      if ((state_q == DRAIN) && bus.dmem_rvalid) begin
        state_d = EMPTY;
      end
      if (commit) begin
        state_d = EMPTY;
      end
      if (accept) begin
        state_d    = bus.mem_is_load ? WAIT_LOAD : FULL;
        heldWen_d  = bus.mem_wen;
        heldAddr_d = bus.mem_waddr;
        heldAlu_d  = bus.mem_alu_result;
        heldType_d = bus.mem_load_type;
        heldLo_d   = bus.mem_addr_lo;
      end
    end
  end

  // State and held-instruction registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      heldWen_q  <= 1'b0;
      heldAddr_q <= 5'd0;
      heldAlu_q  <= 32'd0;
      heldType_q <= 3'd0;
      heldLo_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      heldWen_q  <= heldWen_d;
      heldAddr_q <= heldAddr_d;
      heldAlu_q  <= heldAlu_d;
      heldType_q <= heldType_d;
      heldLo_q   <= heldLo_d;
    end
  end

endmodule
